id_branch_stage: RTL and testbench
==================================

// Module: id_branch_stage
// PURPOSE
//  Decode-side partner of the fetch stage. Consumes the fetch stage's pc/instruction and owns the
//  IF/ID register and the register file. Resolves BEZ/BNE/JMP in ID and drives br_taken/br_addr
//  back to fetch, flushing the wrong-path fetch. Registers decoded operands into the ID/EXE
//  register for the execute stage.
// PARAMETERS
//  REG_COUNT   32  architectural registers; R0 reads 0, writes to R0 are ignored
//  DATA_W      32  register/PC width
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   synchronous, active-high reset
//  if_pc       in   32  pc of instruction presented by fetch this cycle
//  if_instr    in   32  instruction at if_pc
//  freeze      in   1   hazard stall: hold IF/ID, insert bubble into ID/EXE
//  wb_en       in   1   write-back enable
//  wb_dest     in   5   write-back register index
//  wb_value    in   32  write-back data
//  br_taken    out  1   combinational: fetch loads br_addr next edge
//  br_addr     out  32  combinational branch target
//  exe_valid   out  1   ID/EXE entry holds a real instruction
//  exe_pc      out  32  pc of issued instruction
//  exe_opcode  out  6   opcode
//  exe_val1    out  32  src1 value
//  exe_val2    out  32  src2 value (R-type) or sign-extended imm (I-type)
//  exe_dest    out  5   destination index
//  exe_wb_en   out  1   instruction writes a register
// BEHAVIOUR
//  Fields: opcode[31:26], src1[25:21]. R-type: src2[20:16], dest[15:11].
//   I-type: dest[20:16], imm[15:0]. BNE compares src1 with [20:16]. Immediates are sign-extended.
//  IF/ID register: id_valid, id_pc, id_instr.
//   - Reset clears all three.
//   - On taken branch: clear id_valid (flush).
//   - Else when freeze: hold.
//   - Else: load if_pc/if_instr and set id_valid=1.
//  Register file: write on rising edge when wb_en && wb_dest!=0.
//   - Reads are combinational with write-through bypass (same-cycle wb_dest==src returns wb_value).
//   - Contents are NOT cleared by rst. The bench initialises them via write-back.
//  Branch resolve: only when id_valid && !freeze.
//   - BEZ (101000): taken if val1==0.
//   - BNE (101001): taken if val1!=val2.
//   - JMP (101010): always taken.
//   - Target: br_addr = id_pc + 4 + (sext(imm)<<2), wraps mod 2^32.
//   - When not taken, br_taken=0 and br_addr=0.
//  Branch latency: the taken edge loads fetch pc with the target and flushes the one wrong-path
//   instruction in IF/ID. There is exactly one bubble per taken branch.
//  ID/EXE register updates every edge.
//   - rst, freeze, or !id_valid: exe_valid=0 and all exe_* fields cleared to 0.
//   - Otherwise load the decoded fields. exe_wb_en=1 for ALU, load and ADDI classes.
//   - exe_wb_en=0 for NOP, store and branches. Branches still issue with exe_valid=1.
//  Simultaneous events:
//   - rst dominates everything.
//   - freeze suppresses the branch (operands not final), so there is no flush that cycle.
//   - wb and read of the same register in one cycle: bypass value is used for issue and branch compare.
//  Reset mid-operation: all outputs 0 on the edge after rst is sampled; pipeline restarts empty.
// STRUCTURE
//  Package isa_pkg:
//   - Opcode localparams: ADD 000001, SUB 000011, ..., ADDI 100000, LD 100100, ST 100101,
//     BEZ 101000, BNE 101001, JMP 101010.
//   - Field-position constants and OPC_W=6.
//  Sub-module register_file: 2 read ports, 1 write port, bypass, R0 hardwired to 0.
//  Branch compare and target adder stay inline.
// TESTING
//  1 rst held with valid fetch data: exe_valid=0, br_taken=0, all exe_* fields 0 on that edge.
//  2 wb R1=5 then ADD R2,R0,R1 at pc 8: next edge exe_val1=0, exe_val2=5, exe_dest=2,
//    exe_pc=8, exe_wb_en=1.
//  3 BEZ R5, imm=1 at pc 52 with R5=0: br_taken=1, br_addr=60; next edge IF/ID flushed.
//    With R5=3: br_taken=0.
//  4 BNE R1,R3, imm=-15 at pc 192, R1!=R3: br_addr=136. With R1==R3: not taken.
//  5 JMP imm=-1 at pc 256: br_addr=256 (self-loop) and re-taken each time it re-enters ID.
//  6 freeze during BNE in ID: br_taken=0, IF/ID held, exe_valid=0.
//    Release: branch resolves that cycle.
//  7 Same-cycle wb R5=0 and BEZ R5 in ID: taken (bypass).
//    Write to R0 then read R0: reads 0.

Source files
------------

// File: rtl/isa_pkg.sv
// ISA constants shared by the decode stage: opcode encodings, instruction field
// positions and opcode class helpers.
package isa_pkg;

   localparam int OPC_W    = 6;
   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 26;
   localparam int SRC1_MSB = 25;
   localparam int SRC1_LSB = 21;
   localparam int RT_MSB   = 20;
   localparam int RT_LSB   = 16;
   localparam int RD_MSB   = 15;
   localparam int RD_LSB   = 11;
   localparam int IMM_MSB  = 15;
   localparam int IMM_LSB  = 0;
   localparam int IMM_W    = 16;

   localparam logic [OPC_W-1:0] OPC_NOP  = 6'b000000;
   localparam logic [OPC_W-1:0] OPC_ADD  = 6'b000001;
   localparam logic [OPC_W-1:0] OPC_SUB  = 6'b000011;
   localparam logic [OPC_W-1:0] OPC_AND  = 6'b000101;
   localparam logic [OPC_W-1:0] OPC_OR   = 6'b000110;
   localparam logic [OPC_W-1:0] OPC_NOR  = 6'b000111;
   localparam logic [OPC_W-1:0] OPC_XOR  = 6'b001000;
   localparam logic [OPC_W-1:0] OPC_SLA  = 6'b001001;
   localparam logic [OPC_W-1:0] OPC_SLL  = 6'b001010;
   localparam logic [OPC_W-1:0] OPC_SRA  = 6'b001011;
   localparam logic [OPC_W-1:0] OPC_SRL  = 6'b001100;
   localparam logic [OPC_W-1:0] OPC_ADDI = 6'b100000;
   localparam logic [OPC_W-1:0] OPC_LD   = 6'b100100;
   localparam logic [OPC_W-1:0] OPC_ST   = 6'b100101;
   localparam logic [OPC_W-1:0] OPC_BEZ  = 6'b101000;
   localparam logic [OPC_W-1:0] OPC_BNE  = 6'b101001;
   localparam logic [OPC_W-1:0] OPC_JMP  = 6'b101010;

   // R-type formats have a clear opcode MSB; everything else carries an immediate
   function automatic logic is_rtype(input logic [OPC_W-1:0] op);
      return (op[OPC_W-1] == 1'b0);
   endfunction

   function automatic logic writes_reg(input logic [OPC_W-1:0] op);
      logic w;
      case (op)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_NOR, OPC_XOR,
         OPC_SLA, OPC_SLL, OPC_SRA, OPC_SRL:   w = 1'b1;
         OPC_ADDI, OPC_LD:                     w = 1'b1;
         OPC_NOP, OPC_ST:                      w = 1'b0;
         OPC_BEZ, OPC_BNE, OPC_JMP:            w = 1'b0;
         default:                              w = 1'b0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/register_file.sv
// Two-read, one-write register file with same-cycle write-through bypass.
// Entry 0 always reads zero and is never written; contents survive reset.
module register_file #(
   parameter int REG_COUNT = 32,
   parameter int DATA_W    = 32,
   parameter int AW        = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic [AW-1:0]     ra1,
   input  logic [AW-1:0]     ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] regs_r [REG_COUNT];

   // write port; R0 writes are dropped
   always_ff @(posedge clk) begin
      if (we && (wa != {AW{1'b0}})) begin
         regs_r[wa] <= wd;
      end
   end

   // read port 1 with bypass
   always_comb begin
      if (ra1 == {AW{1'b0}}) begin
         rd1 = {DATA_W{1'b0}};
      end else if (we && (wa == ra1)) begin
         rd1 = wd;
      end else begin
         rd1 = regs_r[ra1];
      end
   end

   // read port 2 with bypass
   always_comb begin
      if (ra2 == {AW{1'b0}}) begin
         rd2 = {DATA_W{1'b0}};
      end else if (we && (wa == ra2)) begin
         rd2 = wd;
      end else begin
         rd2 = regs_r[ra2];
      end
   end

endmodule

// File: rtl/id_branch_stage.sv
// Decode stage: IF/ID register, register file, in-ID branch resolution with
// fetch redirect/flush, and the ID/EXE register feeding execute.
module id_branch_stage
   import isa_pkg::*;
#(
   parameter int REG_COUNT = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] if_pc,
   input  logic [31:0]       if_instr,
   input  logic              freeze,
   input  logic              wb_en,
   input  logic [4:0]        wb_dest,
   input  logic [DATA_W-1:0] wb_value,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_addr,
   output logic              exe_valid,
   output logic [DATA_W-1:0] exe_pc,
   output logic [OPC_W-1:0]  exe_opcode,
   output logic [DATA_W-1:0] exe_val1,
   output logic [DATA_W-1:0] exe_val2,
   output logic [4:0]        exe_dest,
   output logic              exe_wb_en
);

   localparam logic [DATA_W-1:0] PC_STEP = {{(DATA_W-3){1'b0}}, 3'b100};

   logic              id_valid_r;
   logic [DATA_W-1:0] id_pc_r;
   logic [31:0]       id_instr_r;

   logic [OPC_W-1:0]  opcode_s;
   logic [4:0]        src1_s;
   logic [4:0]        rt_s;
   logic [4:0]        rd_s;
   logic [DATA_W-1:0] imm_s;
   logic [DATA_W-1:0] rd1_s;
   logic [DATA_W-1:0] rd2_s;
   logic              cond_s;
   logic [DATA_W-1:0] target_s;

   register_file #(
      .REG_COUNT (REG_COUNT),
      .DATA_W    (DATA_W)
   ) u_regfile (
      .clk (clk),
      .ra1 (src1_s),
      .ra2 (rt_s),
      .rd1 (rd1_s),
      .rd2 (rd2_s),
      .we  (wb_en),
      .wa  (wb_dest),
      .wd  (wb_value)
   );

   // field extraction; port 2 always reads [20:16], which also serves BNE
   always_comb begin
      opcode_s = id_instr_r[OPC_MSB:OPC_LSB];
      src1_s   = id_instr_r[SRC1_MSB:SRC1_LSB];
      rt_s     = id_instr_r[RT_MSB:RT_LSB];
      rd_s     = id_instr_r[RD_MSB:RD_LSB];
      imm_s    = {{(DATA_W-IMM_W){id_instr_r[IMM_MSB]}}, id_instr_r[IMM_MSB:IMM_LSB]};
   end

   // branch condition and target; suppressed while frozen since operands may be stale
   always_comb begin
      case (opcode_s)
         OPC_BEZ: cond_s = (rd1_s == {DATA_W{1'b0}});
         OPC_BNE: cond_s = (rd1_s != rd2_s);
         OPC_JMP: cond_s = 1'b1;
         default: cond_s = 1'b0;
      endcase
      target_s = id_pc_r + PC_STEP + {imm_s[DATA_W-3:0], 2'b00};
      if (id_valid_r && !freeze && cond_s) begin
         br_taken = 1'b1;
         br_addr  = target_s;
      end else begin
         br_taken = 1'b0;
         br_addr  = {DATA_W{1'b0}};
      end
   end

   // IF/ID register: flush on taken branch, hold on freeze
   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid_r <= 1'b0;
         id_pc_r    <= {DATA_W{1'b0}};
         id_instr_r <= 32'h0000_0000;
      end else if (br_taken) begin
         id_valid_r <= 1'b0;
      end else if (freeze) begin
         id_valid_r <= id_valid_r;
      end else begin
         id_valid_r <= 1'b1;
         id_pc_r    <= if_pc;
         id_instr_r <= if_instr;
      end
   end

   // ID/EXE register: bubble on reset, freeze or empty ID
   always_ff @(posedge clk) begin
      if (rst || freeze || !id_valid_r) begin
         exe_valid  <= 1'b0;
         exe_pc     <= {DATA_W{1'b0}};
         exe_opcode <= {OPC_W{1'b0}};
         exe_val1   <= {DATA_W{1'b0}};
         exe_val2   <= {DATA_W{1'b0}};
         exe_dest   <= 5'd0;
         exe_wb_en  <= 1'b0;
      end else begin
         exe_valid  <= 1'b1;
         exe_pc     <= id_pc_r;
         exe_opcode <= opcode_s;
         exe_val1   <= rd1_s;
         exe_val2   <= is_rtype(opcode_s) ? rd2_s : imm_s;
         exe_dest   <= is_rtype(opcode_s) ? rd_s : rt_s;
         exe_wb_en  <= writes_reg(opcode_s);
      end
   end

endmodule

// File: tb/tb_id_branch_stage.sv
// Directed self-checking bench for id_branch_stage: reset, issue, branch
// resolve/flush, freeze, bypass and R0 behaviour.
module tb_id_branch_stage;

   localparam logic [5:0] T_NOP = 6'b000000;
   localparam logic [5:0] T_ADD = 6'b000001;
   localparam logic [5:0] T_BEZ = 6'b101000;
   localparam logic [5:0] T_BNE = 6'b101001;
   localparam logic [5:0] T_JMP = 6'b101010;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        freeze;
   logic        wb_en;
   logic [4:0]  wb_dest;
   logic [31:0] wb_value;
   logic        br_taken;
   logic [31:0] br_addr;
   logic        exe_valid;
   logic [31:0] exe_pc;
   logic [5:0]  exe_opcode;
   logic [31:0] exe_val1;
   logic [31:0] exe_val2;
   logic [4:0]  exe_dest;
   logic        exe_wb_en;

   int n_compared;
   int n_mismatched;

   id_branch_stage dut (
      .clk        (clk),
      .rst        (rst),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .freeze     (freeze),
      .wb_en      (wb_en),
      .wb_dest    (wb_dest),
      .wb_value   (wb_value),
      .br_taken   (br_taken),
      .br_addr    (br_addr),
      .exe_valid  (exe_valid),
      .exe_pc     (exe_pc),
      .exe_opcode (exe_opcode),
      .exe_val1   (exe_val1),
      .exe_val2   (exe_val2),
      .exe_dest   (exe_dest),
      .exe_wb_en  (exe_wb_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [4:0] d);
      return {op, s1, s2, d, 11'd0};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s1,
                                         input logic [4:0] d, input logic [15:0] imm);
      return {op, s1, d, imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
      if_pc    = pc;
      if_instr = instr;
   endtask

   task automatic wb(input logic [4:0] d, input logic [31:0] v);
      wb_en    = 1'b1;
      wb_dest  = d;
      wb_value = v;
      tick();
      wb_en    = 1'b0;
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rst      = 1'b1;
      freeze   = 1'b0;
      wb_en    = 1'b0;
      wb_dest  = 5'd0;
      wb_value = 32'd0;
      fetch(32'd8, enc_r(T_ADD, 5'd0, 5'd1, 5'd2));

      // reset held with valid fetch data
      tick();
      tick();
      check_val("rst_exe_valid", {31'd0, exe_valid}, 32'd0);
      check_val("rst_br_taken", {31'd0, br_taken}, 32'd0);
      check_val("rst_br_addr", br_addr, 32'd0);
      check_val("rst_exe_pc", exe_pc, 32'd0);
      check_val("rst_exe_opcode", {26'd0, exe_opcode}, 32'd0);
      check_val("rst_exe_val1", exe_val1, 32'd0);
      check_val("rst_exe_val2", exe_val2, 32'd0);
      check_val("rst_exe_dest", {27'd0, exe_dest}, 32'd0);
      check_val("rst_exe_wb_en", {31'd0, exe_wb_en}, 32'd0);
      rst = 1'b0;
      fetch(32'd4, enc_r(T_NOP, 5'd0, 5'd0, 5'd0));

      wb(5'd1, 32'd5);
      wb(5'd3, 32'd7);
      wb(5'd5, 32'd0);

      // ADD R2,R0,R1 at pc 8
      fetch(32'd8, enc_r(T_ADD, 5'd0, 5'd1, 5'd2));
      tick();
      fetch(32'd12, 32'd0);
      #1;
      check_val("add_no_branch", {31'd0, br_taken}, 32'd0);
      tick();
      check_val("add_valid", {31'd0, exe_valid}, 32'd1);
      check_val("add_pc", exe_pc, 32'd8);
      check_val("add_opcode", {26'd0, exe_opcode}, 32'd1);
      check_val("add_val1", exe_val1, 32'd0);
      check_val("add_val2", exe_val2, 32'd5);
      check_val("add_dest", {27'd0, exe_dest}, 32'd2);
      check_val("add_wb_en", {31'd0, exe_wb_en}, 32'd1);

      // BEZ R5 taken at pc 52, wrong-path ADD flushed
      fetch(32'd52, enc_i(T_BEZ, 5'd5, 5'd0, 16'd1));
      tick();
      fetch(32'd56, enc_r(T_ADD, 5'd1, 5'd1, 5'd9));
      #1;
      check_val("bez_taken", {31'd0, br_taken}, 32'd1);
      check_val("bez_addr", br_addr, 32'd60);
      tick();
      check_val("bez_issue_valid", {31'd0, exe_valid}, 32'd1);
      check_val("bez_issue_pc", exe_pc, 32'd52);
      check_val("bez_issue_wb_en", {31'd0, exe_wb_en}, 32'd0);
      check_val("bez_after_taken", {31'd0, br_taken}, 32'd0);
      fetch(32'd60, 32'd0);
      tick();
      check_val("bez_flush", {31'd0, exe_valid}, 32'd0);

      // BEZ R5 not taken with R5=3
      wb(5'd5, 32'd3);
      fetch(32'd52, enc_i(T_BEZ, 5'd5, 5'd0, 16'd1));
      tick();
      fetch(32'd56, 32'd0);
      #1;
      check_val("bez_nt_taken", {31'd0, br_taken}, 32'd0);
      check_val("bez_nt_addr", br_addr, 32'd0);
      tick();
      tick();
      check_val("bez_nt_next_valid", {31'd0, exe_valid}, 32'd1);
      check_val("bez_nt_next_pc", exe_pc, 32'd56);

      // BNE R1,R3 imm=-15 at pc 192
      fetch(32'd192, enc_i(T_BNE, 5'd1, 5'd3, 16'hFFF1));
      tick();
      fetch(32'd196, 32'd0);
      #1;
      check_val("bne_taken", {31'd0, br_taken}, 32'd1);
      check_val("bne_addr", br_addr, 32'd136);
      tick();
      fetch(32'd136, 32'd0);
      tick();
      wb(5'd3, 32'd5);
      fetch(32'd192, enc_i(T_BNE, 5'd1, 5'd3, 16'hFFF1));
      tick();
      fetch(32'd196, 32'd0);
      #1;
      check_val("bne_eq_taken", {31'd0, br_taken}, 32'd0);
      tick();

      // JMP self-loop at pc 256: taken, one bubble, taken again
      fetch(32'd256, enc_i(T_JMP, 5'd0, 5'd0, 16'hFFFF));
      tick();
      check_val("jmp_taken1", {31'd0, br_taken}, 32'd1);
      check_val("jmp_addr1", br_addr, 32'd256);
      tick();
      check_val("jmp_bubble", {31'd0, br_taken}, 32'd0);
      tick();
      check_val("jmp_taken2", {31'd0, br_taken}, 32'd1);
      check_val("jmp_addr2", br_addr, 32'd256);
      fetch(32'd260, 32'd0);
      tick();
      tick();

      // freeze while BNE sits in ID
      wb(5'd3, 32'd7);
      fetch(32'd192, enc_i(T_BNE, 5'd1, 5'd3, 16'hFFF1));
      tick();
      freeze = 1'b1;
      fetch(32'd500, enc_r(T_ADD, 5'd1, 5'd1, 5'd9));
      #1;
      check_val("frz_no_branch", {31'd0, br_taken}, 32'd0);
      tick();
      check_val("frz_bubble", {31'd0, exe_valid}, 32'd0);
      check_val("frz_still_no_branch", {31'd0, br_taken}, 32'd0);
      freeze = 1'b0;
      #1;
      check_val("frz_release_taken", {31'd0, br_taken}, 32'd1);
      check_val("frz_release_addr", br_addr, 32'd136);
      tick();
      check_val("frz_issue_valid", {31'd0, exe_valid}, 32'd1);
      check_val("frz_issue_pc", exe_pc, 32'd192);
      check_val("frz_issue_opcode", {26'd0, exe_opcode}, {26'd0, T_BNE});
      fetch(32'd136, 32'd0);
      tick();
      check_val("frz_flush", {31'd0, exe_valid}, 32'd0);

      // same-cycle write-back R5=0 with BEZ R5 in ID (R5 holds 3)
      fetch(32'd52, enc_i(T_BEZ, 5'd5, 5'd0, 16'd1));
      tick();
      fetch(32'd56, 32'd0);
      wb_en    = 1'b1;
      wb_dest  = 5'd5;
      wb_value = 32'd0;
      #1;
      check_val("byp_bez_taken", {31'd0, br_taken}, 32'd1);
      check_val("byp_bez_addr", br_addr, 32'd60);
      tick();
      wb_en = 1'b0;
      fetch(32'd60, 32'd0);
      tick();

      // bypass on issue: ADD R6,R5,R1 with same-cycle wb R5=9
      fetch(32'd64, enc_r(T_ADD, 5'd5, 5'd1, 5'd6));
      tick();
      fetch(32'd68, 32'd0);
      wb_en    = 1'b1;
      wb_dest  = 5'd5;
      wb_value = 32'd9;
      tick();
      wb_en = 1'b0;
      check_val("byp_issue_val1", exe_val1, 32'd9);
      check_val("byp_issue_val2", exe_val2, 32'd5);

      // R0 stays zero after a write
      wb(5'd0, 32'd77);
      fetch(32'd72, enc_r(T_ADD, 5'd0, 5'd0, 5'd7));
      tick();
      fetch(32'd76, 32'd0);
      tick();
      check_val("r0_val1", exe_val1, 32'd0);
      check_val("r0_val2", exe_val2, 32'd0);
      check_val("r0_dest", {27'd0, exe_dest}, 32'd7);

      // reset mid-operation with a valid ADD in ID
      fetch(32'd8, enc_r(T_ADD, 5'd0, 5'd1, 5'd2));
      tick();
      rst = 1'b1;
      tick();
      check_val("mid_rst_valid", {31'd0, exe_valid}, 32'd0);
      check_val("mid_rst_pc", exe_pc, 32'd0);
      check_val("mid_rst_val2", exe_val2, 32'd0);
      check_val("mid_rst_dest", {27'd0, exe_dest}, 32'd0);
      check_val("mid_rst_br", {31'd0, br_taken}, 32'd0);
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
